// File: rtl/spi_xfer_engine_pkg.sv
// rtl/spi_xfer_engine_pkg.sv - shared state encodings and status bit positions for the SPI transfer engine
package spi_xfer_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } xfer_state_t;

  localparam int SPIF_BIT  = 7;
  localparam int SPTEF_BIT = 5;

endpackage

// File: rtl/spi_xfer_engine_baud.sv
// rtl/spi_xfer_engine_baud.sv - SCK half-period counter with terminal-count pulse and synchronous clear
module spi_baud_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tc
);

  logic [DIV_W-1:0] cnt;

  assign tc = en && (cnt == div);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_xfer_engine.sv
// rtl/spi_xfer_engine.sv - SPI master engine: holding buffer, shift FSM, SCK/MOSI/MISO, status byte
module spi_xfer_engine
  import spi_xfer_engine_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spe,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsbfe,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_wr,
  input  logic              rd_clr,
  input  logic              miso,
  output logic              sck,
  output logic              mosi,
  output logic              ss_n,
  output logic [DATA_W-1:0] rx_data,
  output logic [7:0]        status_out,
  output logic              sr_en
);

  localparam int ECW = $clog2(2 * DATA_W + 1);

  xfer_state_t       state, state_nx;
  logic [DIV_W-1:0]  div_q;
  logic [ECW-1:0]    edge_cnt, edge_nx;
  logic [DATA_W-1:0] buf_q, tx_sh, rx_sh, rx_nx;
  logic [DATA_W-1:0] out_src, out_shifted;
  logic              out_bit;
  logic              buf_full, buf_full_nx;
  logic              spif, spif_nx;
  logic              tc, cnt_clr, cnt_en;
  logic              start, accept, last_edge, sample_now, shift_now;

  // Counter restarts on every state change so SHIFT and GAP both begin at count 0.
  assign cnt_en  = (state != ST_IDLE);
  assign cnt_clr = (state_nx != state);

  spi_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .div (div_q),
    .tc  (tc)
  );

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (spe && buf_full) begin
          state_nx = ST_SHIFT;
          start    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!spe)                  state_nx = ST_IDLE;
        else if (tc && last_edge)  state_nx = ST_GAP;
      end
      ST_GAP: begin
        if (!spe || tc)            state_nx = ST_IDLE;
      end
      default:                     state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    edge_nx     = edge_cnt + 1'b1;
    last_edge   = (edge_nx == ECW'(2 * DATA_W));
    sample_now  = (state == ST_SHIFT) && tc && (cpha ? !edge_nx[0] : edge_nx[0]);
    shift_now   = (state == ST_SHIFT) && tc && !last_edge && (cpha ? edge_nx[0] : !edge_nx[0]);
    rx_nx       = lsbfe ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
    out_src     = start ? buf_q : tx_sh;
    out_bit     = lsbfe ? out_src[0] : out_src[DATA_W-1];
    out_shifted = lsbfe ? (out_src >> 1) : (out_src << 1);
    // A write in the launch cycle refills the buffer the shift register just emptied.
    accept      = tx_wr && (!buf_full || start);
    buf_full_nx = accept || (buf_full && !start);
    spif_nx     = ((state == ST_SHIFT) && spe && tc && last_edge) || (spif && !rd_clr);
  end

  always_comb begin
    status_out            = '0;
    status_out[SPIF_BIT]  = spif;
    status_out[SPTEF_BIT] = !buf_full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sck      <= cpol;
      mosi     <= 1'b0;
      ss_n     <= 1'b1;
      rx_data  <= '0;
      spif     <= 1'b0;
      buf_full <= 1'b0;
      sr_en    <= 1'b0;
      buf_q    <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      edge_cnt <= '0;
      div_q    <= '0;
    end else begin
      state    <= state_nx;
      buf_full <= buf_full_nx;
      spif     <= spif_nx;
      sr_en    <= (buf_full_nx != buf_full) || (spif_nx != spif);
      if (accept) buf_q <= tx_data;

      case (state)
        ST_IDLE: begin
          sck  <= cpol;
          ss_n <= 1'b1;
          if (start) begin
            ss_n     <= 1'b0;
            div_q    <= baud_div;
            edge_cnt <= '0;
            rx_sh    <= '0;
            if (!cpha) begin
              mosi  <= out_bit;
              tx_sh <= out_shifted;
            end else begin
              tx_sh <= buf_q;
            end
          end
        end
        ST_SHIFT: begin
          if (!spe) begin
            ss_n <= 1'b1;
            sck  <= cpol;
          end else if (tc) begin
            edge_cnt <= edge_nx;
            if (last_edge) begin
              sck     <= cpol;
              ss_n    <= 1'b1;
              rx_data <= sample_now ? rx_nx : rx_sh;
            end else begin
              sck <= ~sck;
            end
            if (sample_now) rx_sh <= rx_nx;
            if (shift_now) begin
              mosi  <= out_bit;
              tx_sh <= out_shifted;
            end
          end
        end
        default: begin
          sck  <= cpol;
          ss_n <= 1'b1;
        end
      endcase
    end
  end

endmodule
